// File: rtl/bp_meta_queue_pkg.sv
// Shared sizing helpers for the branch-predictor metadata queue.
package bp_meta_queue_pkg;
    localparam int unsigned DEFAULT_DEPTH = 8;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Packed entry layout is {pc, pred_taken, metadata}.
    function automatic int unsigned entry_w(input int unsigned vlen,
                                            input int unsigned meta_w);
        return vlen + 1 + meta_w;
    endfunction

    localparam int unsigned DEFAULT_PTR_W = ptr_w(DEFAULT_DEPTH);
endpackage

// File: rtl/config_pkg.sv
// Minimal core configuration slice: only the fields this queue consumes.
package config_pkg;
    typedef struct packed {
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd32};
endpackage

// File: rtl/bp_meta_queue_ram.sv
// DEPTH-entry register array, one write port and one asynchronous read port.
module bp_meta_queue_ram
    import bp_meta_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = 1,
    localparam int unsigned AW = ptr_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/bp_meta_queue.sv
// In-order predictor metadata queue; resolves drive a registered BHT update.
// Define BP_META_QUEUE_STATS_EN to add resolve/mispredict statistics ports.
module bp_meta_queue
    import bp_meta_queue_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter type bht_update_t  = logic,
    parameter type bp_metadata_t = logic,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic                             debug_mode_i,
    input  logic                             push_valid_i,
    output logic                             push_ready_o,
    input  logic [CVA6Cfg.VLEN-1:0]          push_pc_i,
    input  logic                             push_taken_i,
    input  logic [$bits(bp_metadata_t)-1:0]  push_meta_i,
    input  logic                             resolve_valid_i,
    output logic                             resolve_ready_o,
    input  logic                             resolve_taken_i,
    output bht_update_t                      bht_update_o,
    output logic                             mispredict_o,
    output logic [$clog2(DEPTH):0]           count_o
`ifdef BP_META_QUEUE_STATS_EN
    ,
    output logic [31:0]                      stats_resolved_o,
    output logic [31:0]                      stats_mispredict_o
`endif
);
    localparam int unsigned VLEN   = CVA6Cfg.VLEN;
    localparam int unsigned META_W = $bits(bp_metadata_t);
    localparam int unsigned PTR_W  = ptr_w(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W  = entry_w(VLEN, META_W);

    typedef struct packed {
        logic [VLEN-1:0]   pc;
        logic              pred_taken;
        logic [META_W-1:0] meta;
    } entry_t;

    // Same field order as the predictor's update struct.
    typedef struct packed {
        logic              valid;
        logic [VLEN-1:0]   pc;
        logic              taken;
        logic [META_W-1:0] meta;
    } upd_t;

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    upd_t             r_upd;
    logic             r_mis;

    entry_t           w_wentry;
    logic [ENT_W-1:0] w_rdata;
    entry_t           w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_mis;

    assign push_ready_o    = (r_count != CNT_W'(DEPTH));
    assign resolve_ready_o = (r_count != '0);

    assign w_push = push_valid_i && push_ready_o && !flush_i;
    assign w_pop  = resolve_valid_i && resolve_ready_o && !flush_i;

    assign w_wentry = '{pc: push_pc_i, pred_taken: push_taken_i,
                        meta: push_meta_i};
    assign w_head   = entry_t'(w_rdata);
    assign w_mis    = w_pop && (w_head.pred_taken != resolve_taken_i);

    bp_meta_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .i_clk   (clk_i),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (w_wentry),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_upd   <= '0;
            r_mis   <= 1'b0;
        end else if (flush_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_upd.valid <= 1'b0;
            r_mis     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Payload holds its last value between resolves; only valid drops.
            r_upd.valid <= 1'b0;
            r_mis       <= w_mis;
            if (w_pop) begin
                r_upd <= '{valid: !debug_mode_i, pc: w_head.pc,
                           taken: resolve_taken_i, meta: w_head.meta};
            end
        end
    end

    assign bht_update_o = bht_update_t'(r_upd);
    assign mispredict_o = r_mis;
    assign count_o      = r_count;

`ifdef BP_META_QUEUE_STATS_EN
    logic [31:0] r_stat_res;
    logic [31:0] r_stat_mis;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_res <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_pop && (r_stat_res != 32'hFFFF_FFFF)) begin
                r_stat_res <= r_stat_res + 32'd1;
            end
            if (w_mis && (r_stat_mis != 32'hFFFF_FFFF)) begin
                r_stat_mis <= r_stat_mis + 32'd1;
            end
        end
    end

    assign stats_resolved_o   = r_stat_res;
    assign stats_mispredict_o = r_stat_mis;
`endif
endmodule

// File: tb/tb_bp_meta_queue.sv
// Scoreboard bench for bp_meta_queue: directed pushes/resolves, monitor on updates.
module tb_bp_meta_queue;
    typedef logic [3:0] meta_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        meta_t       metadata;
    } upd_t;
    typedef struct packed {
        logic [31:0] pc;
        logic        t;
        meta_t       m;
    } ent_t;
    typedef struct packed {
        upd_t upd;
        logic mis;
    } exp_t;

    localparam config_pkg::cva6_cfg_t CFG = '{VLEN: 32'd32};

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        debug_mode_i;
    logic        push_valid_i;
    logic        push_ready_o;
    logic [31:0] push_pc_i;
    logic        push_taken_i;
    meta_t       push_meta_i;
    logic        resolve_valid_i;
    logic        resolve_ready_o;
    logic        resolve_taken_i;
    upd_t        bht_update_o;
    logic        mispredict_o;
    logic [3:0]  count_o;
`ifdef BP_META_QUEUE_STATS_EN
    logic [31:0] stats_resolved_o;
    logic [31:0] stats_mispredict_o;
    logic [31:0] s_res0;
    logic [31:0] s_mis0;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    ent_t mq[$];

    bp_meta_queue #(
        .CVA6Cfg       (CFG),
        .bht_update_t  (upd_t),
        .bp_metadata_t (meta_t),
        .DEPTH         (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .debug_mode_i    (debug_mode_i),
        .push_valid_i    (push_valid_i),
        .push_ready_o    (push_ready_o),
        .push_pc_i       (push_pc_i),
        .push_taken_i    (push_taken_i),
        .push_meta_i     (push_meta_i),
        .resolve_valid_i (resolve_valid_i),
        .resolve_ready_o (resolve_ready_o),
        .resolve_taken_i (resolve_taken_i),
        .bht_update_o    (bht_update_o),
        .mispredict_o    (mispredict_o),
        .count_o         (count_o)
`ifdef BP_META_QUEUE_STATS_EN
        ,
        .stats_resolved_o   (stats_resolved_o),
        .stats_mispredict_o (stats_mispredict_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Monitor: every presented update/mispredict must match the oldest expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && (bht_update_o.valid || mispredict_o)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got upd=%0h mis=%0b expected none",
                         bht_update_o, mispredict_o);
            end else begin
                e = sb.pop_front();
                if ({bht_update_o, mispredict_o} !== {e.upd, e.mis}) begin
                    errors++;
                    $display("FAIL update: got upd=%0h mis=%0b expected upd=%0h mis=%0b",
                             bht_update_o, mispredict_o, e.upd, e.mis);
                end
            end
        end
    end

    task automatic step(input logic pv, input logic [31:0] pc,
                        input logic pt, input meta_t pm,
                        input logic rv, input logic rt,
                        input logic fl, input logic dbg);
        int   sz;
        ent_t h;
        exp_t e;
        push_valid_i    = pv;
        push_pc_i       = pc;
        push_taken_i    = pt;
        push_meta_i     = pm;
        resolve_valid_i = rv;
        resolve_taken_i = rt;
        flush_i         = fl;
        debug_mode_i    = dbg;
        sz = mq.size();
        if (fl) begin
            mq.delete();
        end else begin
            if (rv && sz > 0) begin
                h = mq.pop_front();
                e.upd.valid    = !dbg;
                e.upd.pc       = h.pc;
                e.upd.taken    = rt;
                e.upd.metadata = h.m;
                e.mis          = (h.t != rt);
                if (!dbg || e.mis) sb.push_back(e);
            end
            if (pv && sz < 8) mq.push_back('{pc: pc, t: pt, m: pm});
        end
        @(posedge clk_i);
        #1;
        push_valid_i    = 1'b0;
        resolve_valid_i = 1'b0;
        flush_i         = 1'b0;
        debug_mode_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 32'h0, 0, 4'h0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        debug_mode_i = 1'b0;
        push_valid_i = 1'b0;
        push_pc_i = '0;
        push_taken_i = 1'b0;
        push_meta_i = '0;
        resolve_valid_i = 1'b0;
        resolve_taken_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_push_ready", 64'(push_ready_o), 64'd1);
        chk("rst_resolve_ready", 64'(resolve_ready_o), 64'd0);
        chk("rst_update", 64'(bht_update_o), 64'd0);
        chk("rst_mispredict", 64'(mispredict_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Single mispredicted branch.
        step(1, 32'h8000_0010, 1, 4'd5, 0, 0, 0, 0);
        chk("one_count", 64'(count_o), 64'd1);
        chk("one_resolve_ready", 64'(resolve_ready_o), 64'd1);
        step(0, 32'h0, 0, 4'h0, 1, 0, 0, 0);
        idle(2);

        // Fill, overfill, drain in order.
        for (int i = 0; i < 8; i++)
            step(1, 32'h100 + 32'(4 * i), i[0], meta_t'(i), 0, 0, 0, 0);
        chk("full_push_ready", 64'(push_ready_o), 64'd0);
        chk("full_count", 64'(count_o), 64'd8);
        step(1, 32'h999, 0, 4'hF, 0, 0, 0, 0);
        chk("full_ignore_count", 64'(count_o), 64'd8);
        for (int i = 0; i < 8; i++)
            step(0, 32'h0, 0, 4'h0, 1, 0, 0, 0);
        chk("drain_resolve_ready", 64'(resolve_ready_o), 64'd0);
        chk("drain_count", 64'(count_o), 64'd0);
        step(0, 32'h0, 0, 4'h0, 1, 1, 0, 0);
        idle(2);

        // Simultaneous push/resolve across pointer wrap.
        step(1, 32'h200, 1, 4'd9, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 32'h204 + 32'(4 * i), 1, meta_t'(i), 1, 1, 0, 0);
            chk("wrap_count", 64'(count_o), 64'd1);
        end
        step(0, 32'h0, 0, 4'h0, 1, 0, 0, 0);
        idle(2);

        // Flush wins over a same-cycle resolve.
        for (int i = 0; i < 4; i++)
            step(1, 32'h400 + 32'(4 * i), 0, meta_t'(i), 0, 0, 0, 0);
        chk("preflush_count", 64'(count_o), 64'd4);
        step(0, 32'h0, 0, 4'h0, 1, 0, 1, 0);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_resolve_ready", 64'(resolve_ready_o), 64'd0);
        idle(2);

        // Debug-mode mismatch: no training, mispredict still pulses.
`ifdef BP_META_QUEUE_STATS_EN
        s_res0 = stats_resolved_o;
        s_mis0 = stats_mispredict_o;
`endif
        step(1, 32'h300, 1, 4'd3, 0, 0, 0, 0);
        step(0, 32'h0, 0, 4'h0, 1, 0, 0, 1);
        chk("debug_count", 64'(count_o), 64'd0);
`ifdef BP_META_QUEUE_STATS_EN
        chk("stats_resolved", 64'(stats_resolved_o), 64'(s_res0 + 32'd1));
        chk("stats_mispredict", 64'(stats_mispredict_o), 64'(s_mis0 + 32'd1));
        chk("stats_total_resolved", 64'(stats_resolved_o), 64'd31);
`endif
        idle(3);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bp_meta_queue.md
# bp_meta_queue

In-order branch-predictor metadata queue on the update side of the local branch predictor's BHT interface. For every predicted branch leaving fetch it captures PC, predicted direction and `bp_metadata_t`. When the branch resolves, it pops that record and drives a registered `bht_update_t` back into the predictor. It also flags mispredictions so the predictor trains with the exact index it used at prediction time.

## Interface
Parameters:
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration; provides `VLEN`.
- `bht_update_t`, default `logic`: update struct `{valid, pc, taken, metadata}`.
- `bp_metadata_t`, default `logic`: predictor metadata (local-predictor index).
- `DEPTH`, default 8: queue entries; power of two, ≥ 2.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `flush_i`, in, 1: discard all queued entries.
- `debug_mode_i`, in, 1: suppress predictor training.
- `push_valid_i`, in, 1: predicted branch to enqueue.
- `push_ready_o`, out, 1: queue can accept.
- `push_pc_i`, in, `VLEN`: branch PC.
- `push_taken_i`, in, 1: predicted direction.
- `push_meta_i`, in, `$bits(bp_metadata_t)`: metadata from `bht_prediction_o`.
- `resolve_valid_i`, in, 1: oldest branch resolved.
- `resolve_ready_o`, out, 1: queue holds an entry.
- `resolve_taken_i`, in, 1: actual direction.
- `bht_update_o`, out, `$bits(bht_update_t)`: update to predictor.
- `mispredict_o`, out, 1: one-cycle pulse on a direction mismatch.
- `count_o`, out, `$clog2(DEPTH)+1`: occupancy.

## Operation
- Circular buffer with read/write pointers of `$clog2(DEPTH)` bits and an occupancy counter; pointers wrap modulo `DEPTH`.
- Push handshake: `push_valid_i && push_ready_o`. Write at the write pointer, then increment it.
- Resolve handshake: `resolve_valid_i && resolve_ready_o`. Read the head, increment the read pointer, and register the update.
- `push_ready_o = (count != DEPTH)`. It does not depend on a same-cycle pop; there is no full-bypass.
- `resolve_ready_o = (count != 0)`. There is no empty-bypass: a push in cycle N cannot be resolved before N+1.
- Simultaneous push and resolve on a non-full, non-empty queue: both happen and the count is unchanged.
- Update contents: `pc` = head PC; `taken` = `resolve_taken_i`; `metadata` = head metadata; `valid` = handshake && !`debug_mode_i`.
- `mispredict_o` = handshake && (head predicted taken != `resolve_taken_i`). It asserts even in debug mode.
- Flush:
  - Pointers and count go to 0 at the next edge.
  - Push and resolve in the flush cycle are ignored.
  - `bht_update_o.valid` and `mispredict_o` are 0 in the following cycle.
- Writing to a full queue or resolving an empty queue is impossible through the handshake; an input asserted without ready is ignored.

## Timing
- Reset (`rst_i` = 1, async): pointers 0, `count_o` 0, `push_ready_o` 1, `resolve_ready_o` 0, `bht_update_o` all zero, `mispredict_o` 0. Entry storage is not reset.
- Push accepted at edge N: `count_o` and `resolve_ready_o` reflect it after N.
- Resolve accepted in cycle N: `bht_update_o.valid` and `mispredict_o` high during N+1 for exactly one cycle (registered outputs).
- Back-to-back resolves give one update per cycle.
- Reset asserted mid-operation: all state clears immediately and any pending registered update is dropped.

## Configuration
- `BP_META_QUEUE_STATS_EN` defined: adds output ports `stats_resolved_o` [31:0] and `stats_mispredict_o` [31:0].
  - Free-running counters, incremented on each resolve handshake and on each mispredict respectively, including in debug mode.
  - Saturate at `32'hFFFF_FFFF`; cleared by reset only, not by flush.
- Macro undefined: these ports and counters do not exist.

## Structure
- Shared package `bp_meta_queue_pkg`: the entry struct `{pc, pred_taken, metadata}` as a parameterised typedef helper, and the localparam for the pointer width.
- `bht_update_t` and `bp_metadata_t` remain type parameters, consistent with the predictor.
- One natural sub-module: `bp_meta_queue_ram`, a `DEPTH`-entry register array with 1 write and 1 async read port. All control stays in the top.

## Test plan
- Reset with push, resolve, flush and debug inputs all 0 → `count_o` = 0, `push_ready_o` = 1, `resolve_ready_o` = 0, `bht_update_o` = 0.
- Push PC `0x8000_0010`, taken = 1, meta = 5; then resolve with taken = 0 → next cycle `bht_update_o` = {1, `0x8000_0010`, 0, 5} and `mispredict_o` = 1.
- Push 8 entries with PCs `0x100`+4·i → `push_ready_o` = 0 and `count_o` = 8.
  - Push during full is ignored.
  - 8 resolves return PCs `0x100`..`0x11C` in order, then `resolve_ready_o` = 0.
- Pointer wrap: interleave one push and one resolve per cycle for 20 cycles → `count_o` stays 1 and updates carry PCs in push order across the wrap.
- Flush with 4 entries queued and `resolve_valid_i` = 1 in the same cycle → next cycle `count_o` = 0, no update valid, no mispredict.
- `debug_mode_i` = 1 during a mismatching resolve → `bht_update_o.valid` = 0, `mispredict_o` = 1, entry popped.
  - With `BP_META_QUEUE_STATS_EN`: both stats counters increment by 1.
